// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares one single-port, synchronous-read data memory between the CPU
//   MEM stage and the UART debug/loader port. One requester is granted per
//   cycle. The CPU wins contested cycles until debug has waited MAX_DBG_WAIT
//   contested cycles, after which debug is forced a grant. Each read response
//   is steered back to the requester that issued it, one cycle after grant.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/we/be/addr/wdata   CPU access request (level, held while stalled)
//   cpu_stall                  CPU lost arbitration (or arbiter not ready)
//   cpu_rvalid, cpu_rdata      CPU load return
//   dbg_req/we/addr/wdata      debug access request (level, held until gnt)
//   dbg_gnt                    debug request accepted this cycle
//   dbg_rvalid, dbg_rdata      debug read return
//   mem_en/we/be/addr/wdata    memory command from the winning requester
//   mem_rdata                  memory read data (valid cycle after a read)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DBG_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_be,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Owner of the read whose data appears on mem_rdata this cycle.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_DBG_WAIT);

    logic       arb_ready_r;
    logic [3:0] wait_cnt_r;
    logic [1:0] rd_owner_r;

    logic       cpu_gnt_s;
    logic       dbg_gnt_s;
    logic [3:0] wait_cnt_nxt_s;
    logic [1:0] rd_owner_nxt_s;

    // Grant decision: single requester wins; on contention the CPU wins
    // unless debug has already waited the full bound.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (arb_ready_r) begin
            if (dbg_req && (!cpu_req || (wait_cnt_r == MAX_WAIT_C))) begin
                dbg_gnt_s = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b0;
            end
        end else begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end
    end

    // Memory command mux; idle command keeps we/be low so a disabled
    // cycle never looks like a write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        case ({dbg_gnt_s, cpu_gnt_s})
            2'b01: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_be    = cpu_be;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            2'b10: begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_be    = 4'b1111;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: begin
                mem_en = 1'b0;
                mem_we = 1'b0;
                mem_be = 4'b0000;
            end
        endcase
    end

    // Contention counter: counts CPU wins while debug waits, saturating at
    // the bound so the forced debug grant happens exactly once per wait.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (dbg_gnt_s || !dbg_req) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (cpu_gnt_s) begin
            if (wait_cnt_r == MAX_WAIT_C) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + 4'd1;
            end
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Read-return tag: remember who issued this cycle's read, writes and
    // idle cycles leave nothing in flight.
    always_comb begin
        rd_owner_nxt_s = OWN_NONE;
        if (cpu_gnt_s && !cpu_we) begin
            rd_owner_nxt_s = OWN_CPU;
        end else if (dbg_gnt_s && !dbg_we) begin
            rd_owner_nxt_s = OWN_DBG;
        end else begin
            rd_owner_nxt_s = OWN_NONE;
        end
    end

    // Arbiter state; async reset discards any in-flight read immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_ready_r <= 1'b0;
            wait_cnt_r  <= 4'd0;
            rd_owner_r  <= OWN_NONE;
        end else begin
            arb_ready_r <= 1'b1;
            wait_cnt_r  <= wait_cnt_nxt_s;
            rd_owner_r  <= rd_owner_nxt_s;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt_s;
    assign dbg_gnt    = dbg_gnt_s;
    assign cpu_rvalid = (rd_owner_r == OWN_CPU);
    assign dbg_rvalid = (rd_owner_r == OWN_DBG);
    // Data is shared; each side qualifies it with its own rvalid.
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Purpose:
//   Self-checking bench for dmem_port_arbiter. A behavioural 128x32 memory
//   sits on the mem_* port. Expected read returns are queued when a read is
//   expected to be granted and popped one cycle later when the DUT returns.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    localparam logic [1:0] OWN_CPU = 2'd1;
    localparam logic [1:0] OWN_DBG = 2'd2;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] data;
    } ret_t;

    logic          clk;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [3:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem_model [128];
    logic [DW-1:0] shadow    [128];
    ret_t          sb_q [$];

    int n_checks;
    int n_errors;

    dmem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_DBG_WAIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural synchronous-read memory with byte-enable writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock and compare read-return outputs with the scoreboard.
    task automatic tick();
        ret_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(e.owner == OWN_CPU));
            check_eq("dbg_rvalid", 32'(dbg_rvalid), 32'(e.owner == OWN_DBG));
            if (e.owner == OWN_CPU) check_eq("cpu_rdata", cpu_rdata, e.data);
            else                    check_eq("dbg_rdata", dbg_rdata, e.data);
        end else begin
            check_eq("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
            check_eq("dbg_rvalid_idle", 32'(dbg_rvalid), 32'd0);
        end
    endtask

    // Drive one cycle of requests, check the grant outputs mid-cycle,
    // update the expected memory image and queue expected read returns.
    task automatic drive_cycle(
        input logic cr, input logic cwe, input logic [3:0] cbe,
        input logic [AW-1:0] ca, input logic [31:0] cd,
        input logic dr, input logic dwe,
        input logic [AW-1:0] da, input logic [31:0] dd,
        input logic ecg, input logic edg);
        ret_t e;
        cpu_req = cr;  cpu_we = cwe; cpu_be = cbe; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr;  dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
        @(negedge clk);
        check_eq("cpu_stall", 32'(cpu_stall), 32'(cr & ~ecg));
        check_eq("dbg_gnt",   32'(dbg_gnt),   32'(edg));
        check_eq("mem_en",    32'(mem_en),    32'(ecg | edg));
        if (ecg) begin
            check_eq("mem_we_cpu",   32'(mem_we),   32'(cwe));
            check_eq("mem_addr_cpu", 32'(mem_addr), 32'(ca));
            if (cwe) begin
                check_eq("mem_be_cpu",    32'(mem_be), 32'(cbe));
                check_eq("mem_wdata_cpu", mem_wdata,   cd);
                for (int b = 0; b < 4; b++) begin
                    if (cbe[b]) shadow[ca][8*b +: 8] = cd[8*b +: 8];
                end
            end else begin
                e.owner = OWN_CPU;
                e.data  = shadow[ca];
                sb_q.push_back(e);
            end
        end else if (edg) begin
            check_eq("mem_we_dbg",   32'(mem_we),   32'(dwe));
            check_eq("mem_addr_dbg", 32'(mem_addr), 32'(da));
            check_eq("mem_be_dbg",   32'(mem_be),   32'hF);
            if (dwe) begin
                check_eq("mem_wdata_dbg", mem_wdata, dd);
                shadow[da] = dd;
            end else begin
                e.owner = OWN_DBG;
                e.data  = shadow[da];
                sb_q.push_back(e);
            end
        end else begin
            check_eq("mem_we_idle", 32'(mem_we), 32'd0);
            check_eq("mem_be_idle", 32'(mem_be), 32'd0);
        end
        tick();
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [AW-1:0] ca;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 128; i++) begin
            mem_model[i] = 32'hA500_0000 ^ 32'(i * 32'h0101_0101);
            shadow[i]    = mem_model[i];
        end
        mem_model[5] = 32'hDEAD_BEEF;
        shadow[5]    = 32'hDEAD_BEEF;
        mem_rdata = 32'd0;

        // Reset with the CPU already requesting: stall follows request.
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 7'd7; cpu_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 7'd0; dbg_wdata = 32'd0;
        @(negedge clk);
        check_eq("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        check_eq("rst_mem_en",    32'(mem_en),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // First cycle after release is not yet ready; then the load at 5.
        drive_cycle(1'b1, 1'b0, 4'h0, 7'd7, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 4'h0, 7'd5, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
        idle_cycle();

        // Continuous CPU loads against a waiting debug write: debug forced
        // on the fifth contested cycle, CPU address held while stalled.
        ca = 7'd10;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b0, 4'h0, ca, 32'd0,
                        (i <= 4), 1'b1, 7'd20, 32'hCAFE_F00D,
                        (i != 4), (i == 4));
            if (i != 4) ca = ca + 7'd1;
        end
        idle_cycle();

        // Debug write with CPU idle: no read return follows.
        drive_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'd0, 1'b1, 1'b1, 7'd0, 32'h1234_5678, 1'b0, 1'b1);

        // Debug read then CPU read back-to-back: returns routed per owner.
        drive_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd3, 32'd0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 4'h0, 7'd4, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
        idle_cycle();

        // Read back debug-written words.
        drive_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd20, 32'd0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0,  32'd0, 1'b0, 1'b1);

        // CPU half-word store then load of the merged word.
        drive_cycle(1'b1, 1'b1, 4'b0011, 7'd5, 32'h1122_3344, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 4'h0, 7'd5, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
        check_eq("merged_word", shadow[5], 32'hDEAD_3344);

        // Granted CPU read, then reset during its return cycle.
        drive_cycle(1'b1, 1'b0, 4'h0, 7'd9, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("midrst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check_eq("midrst_cpu_stall",  32'(cpu_stall),  32'd1);
        check_eq("midrst_mem_en",     32'(mem_en),     32'd0);
        tick();
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, 4'h0, 7'd9, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name:
dmem_port_arbiter

Overview:
Shares the single-port, synchronous-read data memory (128 x 32) between the CPU pipeline MEM stage and the UART debug/loader port. It grants one requester per cycle and stalls the CPU when it loses arbitration. A bounded-wait rule guarantees debug access under continuous CPU traffic. Each read response is routed back to the requester that issued it.

Parameters:
ADDR_WIDTH, 7, word address width (DATA_MEM_DEPTH = 128 words)
DATA_WIDTH, 32, data word width
MAX_DBG_WAIT, 4, consecutive contested cycles the CPU may win before debug is forced a grant (1..15)

Ports:
clk  input  1  system clock, all registers rising-edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU memory access request (level, held while cpu_stall=1)
cpu_we  input  1  CPU write enable (1=store, 0=load)
cpu_be  input  4  CPU byte enables for stores
cpu_addr  input  ADDR_WIDTH  CPU word address
cpu_wdata  input  DATA_WIDTH  CPU store data
cpu_stall  output  1  CPU request not granted this cycle; pipeline must hold
cpu_rvalid  output  1  cpu_rdata valid (one cycle after a granted CPU load)
cpu_rdata  output  DATA_WIDTH  CPU load data
dbg_req  input  1  debug request (level, held until dbg_gnt)
dbg_we  input  1  debug write enable
dbg_addr  input  ADDR_WIDTH  debug word address
dbg_wdata  input  DATA_WIDTH  debug write data (always full word)
dbg_gnt  output  1  debug request accepted this cycle
dbg_rvalid  output  1  dbg_rdata valid (one cycle after a granted debug read)
dbg_rdata  output  DATA_WIDTH  debug read data
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_be  output  4  memory byte enables
mem_addr  output  ADDR_WIDTH  memory word address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Registers: arb_ready, wait_cnt[3:0], rd_owner[1:0] (NONE/CPU/DBG). Reset values: arb_ready=0, wait_cnt=0, rd_owner=NONE.
- arb_ready is set on the first clock edge after reset release. While arb_ready=0: no grants, mem_en=0, cpu_stall=cpu_req, dbg_gnt=0.
- Grant logic is combinational from the requests, arb_ready and wait_cnt:
  - Only one request active: that requester wins.
  - Both active: debug wins iff wait_cnt==MAX_DBG_WAIT; otherwise the CPU wins.
- Outputs from the grant:
  - cpu_stall = cpu_req & ~cpu_gnt; dbg_gnt = debug win.
  - mem_en = any grant; mem_* fields are muxed from the winner.
  - For debug access mem_be=4'b1111. With no grant, mem_we=0 and mem_be=0.
- wait_cnt update:
  - Increments (saturating at MAX_DBG_WAIT) when both requests are active and the CPU wins.
  - Clears when debug is granted or dbg_req=0.
  - Holds when the CPU is idle and debug waits (cannot occur, since debug would be granted).
- Read return:
  - rd_owner <= CPU/DBG on a granted read, NONE otherwise.
  - cpu_rvalid = (rd_owner==CPU); dbg_rvalid = (rd_owner==DBG). Latency is exactly 1 cycle from grant.
  - cpu_rdata and dbg_rdata both pass mem_rdata through; each is qualified only by its rvalid.
  - Writes produce no rvalid.
- Back-to-back: a new grant is allowed every cycle, including a grant in the same cycle as the previous read's return. Alternating winners route correctly through rd_owner.
- Reset asserted mid-operation: rd_owner->NONE and both rvalids drop immediately (async). An in-flight read is discarded. arb_ready->0, so cpu_stall follows cpu_req.
- Requests with addresses outside the depth do not occur (width-limited). There are no error responses.

Test Plan:
- Reset then release with cpu_req=1 -> cycle 0 after release cpu_stall=1, mem_en=0; next cycle mem_en=1, cpu_stall=0.
- CPU-only load at addr 5, memory word 0xDEADBEEF -> mem_en=1, mem_we=0, mem_addr=5; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- cpu_req held high for 8 cycles, dbg_req asserted at cycle 0 with MAX_DBG_WAIT=4 -> CPU granted cycles 0-3; cycle 4 dbg_gnt=1, cpu_stall=1; cycles 5-7 CPU granted again.
- Debug write 0x12345678 to addr 0 with CPU idle -> same cycle dbg_gnt=1, mem_we=1, mem_be=4'hF; no rvalid follows.
- Debug read at addr 3 in cycle N, CPU read at addr 4 in cycle N+1 -> dbg_rvalid in N+1 only, cpu_rvalid in N+2 only, each with its own word.
- Reset asserted in the cycle after a granted CPU read -> cpu_rvalid=0 immediately; after release, no spurious rvalid.
